// File: rtl/collision_arbiter_2p.sv
// Frame-level collision controller for the two-player game: time-shares one external
// equality comparator between both players, tracks lives and declares the winner.
module collision_arbiter_2p #(
  parameter int unsigned POS_DATAWIDTH = 8,
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned LIVES_WIDTH   = 2
) (
  input  logic                     SC_COLARB_CLOCK_50,
  input  logic                     SC_COLARB_RESET_InHigh,
  input  logic                     tick_In,
  input  logic [POS_DATAWIDTH-1:0] fila0_In,
  input  logic [POS_DATAWIDTH-1:0] posjug1_In,
  input  logic [POS_DATAWIDTH-1:0] posjug2_In,
  input  logic                     cmp_match_In,
  output logic [POS_DATAWIDTH-1:0] cmp_fila_Out,
  output logic [POS_DATAWIDTH-1:0] cmp_pos_Out,
  output logic                     collide1_Out,
  output logic                     collide2_Out,
  output logic                     done_Out,
  output logic                     busy_Out,
  output logic [LIVES_WIDTH-1:0]   lives1_Out,
  output logic [LIVES_WIDTH-1:0]   lives2_Out,
  output logic                     gameover_Out,
  output logic [1:0]               winner_Out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP_J1,
    S_CMP_J2,
    S_UPDATE,
    S_OVER
  } state_t;

  state_t                   state_q;
  logic [POS_DATAWIDTH-1:0] fila_q, pos1_q, pos2_q;
  logic [POS_DATAWIDTH-1:0] cmp_fila_q, cmp_pos_q;
  logic                     hit1_q, hit2_q, pending_q;
  logic                     collide1_q, collide2_q, done_q, busy_q, gameover_q;
  logic [1:0]               winner_q;
  logic [LIVES_WIDTH-1:0]   lives1_q, lives2_q;
  logic [LIVES_WIDTH-1:0]   lives1_d, lives2_d;
  logic                     hit1_c, hit2_c, over_c;

  // A player with an empty position mask can never be hit.
  always_comb begin
    hit1_c   = cmp_match_In && (pos1_q != '0);
    hit2_c   = cmp_match_In && (pos2_q != '0);
    lives1_d = lives1_q;
    lives2_d = lives2_q;
    if (hit1_q && (lives1_q != '0)) lives1_d = lives1_q - LIVES_WIDTH'(1);
    if (hit2_q && (lives2_q != '0)) lives2_d = lives2_q - LIVES_WIDTH'(1);
    over_c   = (lives1_d == '0) || (lives2_d == '0);
  end

  always_ff @(posedge SC_COLARB_CLOCK_50) begin
    if (SC_COLARB_RESET_InHigh) begin
      state_q    <= S_IDLE;
      fila_q     <= '0;
      pos1_q     <= '0;
      pos2_q     <= '0;
      cmp_fila_q <= '0;
      cmp_pos_q  <= '0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      pending_q  <= 1'b0;
      collide1_q <= 1'b0;
      collide2_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      gameover_q <= 1'b0;
      winner_q   <= 2'b00;
      lives1_q   <= LIVES_WIDTH'(INIT_LIVES);
      lives2_q   <= LIVES_WIDTH'(INIT_LIVES);
    end else begin
      done_q     <= 1'b0;
      collide1_q <= 1'b0;
      collide2_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A pending tick left over from the last UPDATE starts a frame too.
          if (tick_In || pending_q) begin
            fila_q     <= fila0_In;
            pos1_q     <= posjug1_In;
            pos2_q     <= posjug2_In;
            cmp_fila_q <= fila0_In & posjug1_In;
            cmp_pos_q  <= posjug1_In;
            pending_q  <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_CMP_J1;
          end
        end
        S_CMP_J1: begin
          hit1_q     <= hit1_c;
          cmp_fila_q <= fila_q & pos2_q;
          cmp_pos_q  <= pos2_q;
          if (tick_In) pending_q <= 1'b1;
          state_q    <= S_CMP_J2;
        end
        S_CMP_J2: begin
          hit2_q     <= hit2_c;
          done_q     <= 1'b1;
          collide1_q <= hit1_q;
          collide2_q <= hit2_c;
          if (tick_In) pending_q <= 1'b1;
          state_q    <= S_UPDATE;
        end
        S_UPDATE: begin
          lives1_q <= lives1_d;
          lives2_q <= lives2_d;
          if (over_c) begin
            gameover_q <= 1'b1;
            winner_q   <= {lives1_d == '0, lives2_d == '0};
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_OVER;
          end else if (pending_q) begin
            fila_q     <= fila0_In;
            pos1_q     <= posjug1_In;
            pos2_q     <= posjug2_In;
            cmp_fila_q <= fila0_In & posjug1_In;
            cmp_pos_q  <= posjug1_In;
            pending_q  <= tick_In;
            state_q    <= S_CMP_J1;
          end else begin
            pending_q <= tick_In;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_OVER: begin
          state_q <= S_OVER;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmp_fila_Out = cmp_fila_q;
  assign cmp_pos_Out  = cmp_pos_q;
  assign collide1_Out = collide1_q;
  assign collide2_Out = collide2_q;
  assign done_Out     = done_q;
  assign busy_Out     = busy_q;
  assign lives1_Out   = lives1_q;
  assign lives2_Out   = lives2_q;
  assign gameover_Out = gameover_q;
  assign winner_Out   = winner_q;

endmodule

// File: tb/tb_collision_arbiter_2p.sv
// Directed bench for collision_arbiter_2p with a behavioural equality comparator.
module tb_collision_arbiter_2p;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] fila = '0, pos1 = '0, pos2 = '0;
  logic       cmp_match;
  logic [7:0] cmp_fila, cmp_pos;
  logic       collide1, collide2, done, busy, gameover;
  logic [1:0] lives1, lives2, winner;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // The shared external comparator.
  assign cmp_match = (cmp_fila == cmp_pos);

  collision_arbiter_2p #(
    .POS_DATAWIDTH(8),
    .INIT_LIVES(3),
    .LIVES_WIDTH(2)
  ) dut (
    .SC_COLARB_CLOCK_50(clk),
    .SC_COLARB_RESET_InHigh(rst),
    .tick_In(tick),
    .fila0_In(fila),
    .posjug1_In(pos1),
    .posjug2_In(pos2),
    .cmp_match_In(cmp_match),
    .cmp_fila_Out(cmp_fila),
    .cmp_pos_Out(cmp_pos),
    .collide1_Out(collide1),
    .collide2_Out(collide2),
    .done_Out(done),
    .busy_Out(busy),
    .lives1_Out(lives1),
    .lives2_Out(lives2),
    .gameover_Out(gameover),
    .winner_Out(winner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    tick = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // Tick in cycle 0, capture pulses in cycle 3, return positioned at cycle 4.
  task automatic run_frame(input logic [7:0] f, input logic [7:0] p1, input logic [7:0] p2,
                           output logic d, output logic c1, output logic c2);
    fila = f; pos1 = p1; pos2 = p2; tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    d = done; c1 = collide1; c2 = collide2;
    cyc();
  endtask

  logic d, c1, c2;

  initial begin
    do_reset();
    check("rst_lives1", 32'(lives1), 32'd3);
    check("rst_lives2", 32'(lives2), 32'd3);
    check("rst_gameover", 32'(gameover), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Basic latency; inputs scrambled after the snapshot.
    fila = 8'h18; pos1 = 8'h10; pos2 = 8'h01; tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("t1_c1_opA", 32'(cmp_fila), 32'h10);
    check("t1_c1_opB", 32'(cmp_pos), 32'h10);
    check("t1_c1_busy", 32'(busy), 32'd1);
    fila = 8'h00; pos1 = 8'hAA; pos2 = 8'h55;
    cyc();
    check("t1_c2_opA", 32'(cmp_fila), 32'h00);
    check("t1_c2_opB", 32'(cmp_pos), 32'h01);
    cyc();
    check("t1_c3_done", 32'(done), 32'd1);
    check("t1_c3_col1", 32'(collide1), 32'd1);
    check("t1_c3_col2", 32'(collide2), 32'd0);
    cyc();
    check("t1_c4_lives1", 32'(lives1), 32'd2);
    check("t1_c4_lives2", 32'(lives2), 32'd3);
    check("t1_c4_done", 32'(done), 32'd0);
    check("t1_c4_busy", 32'(busy), 32'd0);
    check("t1_c4_opA_hold", 32'(cmp_fila), 32'h00);
    check("t1_c4_opB_hold", 32'(cmp_pos), 32'h01);

    // Empty P1 position is never a hit even though the comparator matches.
    do_reset();
    run_frame(8'hFF, 8'h00, 8'h04, d, c1, c2);
    check("t2_done", 32'(d), 32'd1);
    check("t2_col1", 32'(c1), 32'd0);
    check("t2_col2", 32'(c2), 32'd1);
    check("t2_lives1", 32'(lives1), 32'd3);
    check("t2_lives2", 32'(lives2), 32'd2);

    // P1 loses all lives.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_frame(8'hFF, 8'h02, 8'h00, d, c1, c2);
      check($sformatf("t3_col1_%0d", i), 32'(c1), 32'd1);
      check($sformatf("t3_col2_%0d", i), 32'(c2), 32'd0);
      check($sformatf("t3_lives1_%0d", i), 32'(lives1), 32'(2 - i));
    end
    check("t3_gameover", 32'(gameover), 32'd1);
    check("t3_winner", 32'(winner), 32'b10);
    check("t3_lives2", 32'(lives2), 32'd3);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    check("t3_ign_busy", 32'(busy), 32'd0);
    cyc();
    check("t3_ign_done", 32'(done), 32'd0);
    cyc();
    check("t3_ign_lives1", 32'(lives1), 32'd0);
    check("t3_ign_lives2", 32'(lives2), 32'd3);
    check("t3_ign_gameover", 32'(gameover), 32'd1);

    // Simultaneous hit drains both players to zero together.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_frame(8'hFF, 8'h01, 8'h80, d, c1, c2);
      check($sformatf("t4_col_%0d", i), 32'({c1, c2}), 32'b11);
      check($sformatf("t4_lives1_%0d", i), 32'(lives1), 32'(2 - i));
      check($sformatf("t4_lives2_%0d", i), 32'(lives2), 32'(2 - i));
      check($sformatf("t4_gameover_%0d", i), 32'(gameover), (i == 2) ? 32'd1 : 32'd0);
    end
    check("t4_winner", 32'(winner), 32'b11);

    // Ticks at cycles 0,1,2: two frames, second snapshots cycle-3 inputs.
    do_reset();
    fila = 8'hFF; pos1 = 8'h01; pos2 = 8'h00; tick = 1'b1;
    cyc();
    fila = 8'h00; pos1 = 8'h11; pos2 = 8'h22;
    cyc();
    cyc();
    tick = 1'b0;
    check("t5_c3_done", 32'(done), 32'd1);
    check("t5_c3_col", 32'({collide1, collide2}), 32'b10);
    fila = 8'hFF; pos1 = 8'h00; pos2 = 8'h08;
    cyc();
    check("t5_c4_done", 32'(done), 32'd0);
    check("t5_c4_busy", 32'(busy), 32'd1);
    check("t5_c4_lives1", 32'(lives1), 32'd2);
    check("t5_c4_opB", 32'(cmp_pos), 32'h00);
    fila = 8'h00; pos1 = 8'h01; pos2 = 8'h01;
    cyc();
    check("t5_c5_opA", 32'(cmp_fila), 32'h08);
    check("t5_c5_done", 32'(done), 32'd0);
    cyc();
    check("t5_c6_done", 32'(done), 32'd1);
    check("t5_c6_col", 32'({collide1, collide2}), 32'b01);
    cyc();
    check("t5_c7_lives2", 32'(lives2), 32'd2);
    check("t5_c7_busy", 32'(busy), 32'd0);
    cyc();
    check("t5_c8_done", 32'(done), 32'd0);
    cyc();
    check("t5_c9_done", 32'(done), 32'd0);
    check("t5_c9_busy", 32'(busy), 32'd0);

    // Reset mid-frame abandons it.
    do_reset();
    fila = 8'hFF; pos1 = 8'h01; pos2 = 8'h00; tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_c3_done", 32'(done), 32'd0);
    check("t6_c3_col1", 32'(collide1), 32'd0);
    check("t6_c3_busy", 32'(busy), 32'd0);
    check("t6_c3_lives1", 32'(lives1), 32'd3);
    cyc();
    check("t6_c4_done", 32'(done), 32'd0);
    check("t6_c4_lives1", 32'(lives1), 32'd3);
    check("t6_c4_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
